// File: rtl/carregador_programa.sv
// Program loader: sweeps a 256x8 instruction memory to zero, accepts a
// length-prefixed byte stream into it, then serves combinational fetches.
module carregador_programa (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DadoEntrada,
  input  logic       ValidoEntrada,
  output logic       ProntoEntrada,
  input  logic       Recarregar,
  input  logic [7:0] SaidaPC,
  output logic [7:0] Instrucao,
  output logic       CpuHabilita,
  output logic       Carregado,
  output logic [8:0] TamanhoCarregado
);

  typedef enum logic [1:0] {
    LIMPA      = 2'd0,
    ESPERA_TAM = 2'd1,
    CARREGA    = 2'd2,
    EXECUTA    = 2'd3
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [8:0] contador_q, contador_d;
  logic [7:0] n_q, n_d;
  logic       carregado_q, carregado_d;
  logic [8:0] tamanho_q, tamanho_d;

  logic [7:0] mem [256];
  logic       we;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       transfer;

  assign ProntoEntrada    = (estado_q == ESPERA_TAM) || (estado_q == CARREGA);
  assign CpuHabilita      = (estado_q == EXECUTA);
  assign Carregado        = carregado_q;
  assign TamanhoCarregado = tamanho_q;
  assign transfer         = ValidoEntrada && ProntoEntrada;
  assign Instrucao        = (estado_q == EXECUTA) ? mem[SaidaPC] : 8'h00;

  always_comb begin
    estado_d    = estado_q;
    contador_d  = contador_q;
    n_d         = n_q;
    carregado_d = carregado_q;
    tamanho_d   = tamanho_q;
    we          = 1'b0;
    waddr       = contador_q[7:0];
    wdata       = 8'h00;
    case (estado_q)
      LIMPA: begin
        we         = 1'b1;
        contador_d = contador_q + 9'd1;
        if (contador_q == 9'd255) begin
          estado_d = ESPERA_TAM;
        end
      end
      ESPERA_TAM: begin
        if (transfer) begin
          n_d        = DadoEntrada;
          contador_d = '0;
          if (DadoEntrada == 8'h00) begin
            estado_d    = EXECUTA;
            tamanho_d   = '0;
            carregado_d = 1'b1;
          end else begin
            estado_d = CARREGA;
          end
        end
      end
      CARREGA: begin
        if (transfer) begin
          we         = 1'b1;
          wdata      = DadoEntrada;
          contador_d = contador_q + 9'd1;
          // N is nonzero here, so N-1 cannot wrap
          if (contador_q[7:0] == (n_q - 8'd1)) begin
            tamanho_d   = {1'b0, n_q};
            carregado_d = 1'b1;
            estado_d    = EXECUTA;
          end
        end
      end
      EXECUTA: begin
        if (Recarregar) begin
          carregado_d = 1'b0;
          contador_d  = '0;
          estado_d    = LIMPA;
        end
      end
      default: estado_d = LIMPA;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q    <= LIMPA;
      contador_q  <= '0;
      n_q         <= '0;
      carregado_q <= 1'b0;
      tamanho_q   <= '0;
    end else begin
      estado_q    <= estado_d;
      contador_q  <= contador_d;
      n_q         <= n_d;
      carregado_q <= carregado_d;
      tamanho_q   <= tamanho_d;
    end
  end

  // Memory has no reset; the LIMPA sweep after every reset zeroes it.
  always_ff @(posedge Clock) begin
    if (we && !Reset) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_carregador_programa.sv
// Randomized scoreboard bench for carregador_programa against a
// memory-image reference model of the load protocol.
module tb_carregador_programa;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] DadoEntrada = '0;
  logic       ValidoEntrada = 1'b0;
  logic       ProntoEntrada;
  logic       Recarregar = 1'b0;
  logic [7:0] SaidaPC = '0;
  logic [7:0] Instrucao;
  logic       CpuHabilita;
  logic       Carregado;
  logic [8:0] TamanhoCarregado;

  carregador_programa dut (
    .Clock            (clk),
    .Reset            (Reset),
    .DadoEntrada      (DadoEntrada),
    .ValidoEntrada    (ValidoEntrada),
    .ProntoEntrada    (ProntoEntrada),
    .Recarregar       (Recarregar),
    .SaidaPC          (SaidaPC),
    .Instrucao        (Instrucao),
    .CpuHabilita      (CpuHabilita),
    .Carregado        (Carregado),
    .TamanhoCarregado (TamanhoCarregado)
  );

  always #5 clk = ~clk;

  localparam int K_INSTR  = 0;
  localparam int K_PRONTO = 1;
  localparam int K_CPU    = 2;
  localparam int K_CARR   = 3;
  localparam int K_TAM    = 4;

  typedef struct {
    int         kind;
    logic [8:0] exp;
    string      name;
  } item_t;

  item_t sb[$];
  int    tests = 0;
  int    fails = 0;

  logic [7:0] model_mem [256];
  int         model_len = 0;
  bit         model_loaded = 1'b0;
  bit         force_gap = 1'b0;

  // Monitor: compares everything queued against what the DUT presents.
  initial begin
    item_t      it;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.kind)
          K_INSTR:  act = {1'b0, Instrucao};
          K_PRONTO: act = {8'h00, ProntoEntrada};
          K_CPU:    act = {8'h00, CpuHabilita};
          K_CARR:   act = {8'h00, Carregado};
          default:  act = TamanhoCarregado;
        endcase
        tests++;
        if (act !== it.exp) begin
          fails++;
          $display("FAIL %s: actual %0h required %0h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push(input int k, input logic [8:0] e, input string nm);
    item_t it;
    it.kind = k;
    it.exp  = e;
    it.name = nm;
    sb.push_back(it);
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic push_idle(input string tag, input bit pronto);
    push(K_PRONTO, {8'h00, pronto}, {tag, "_pronto"});
    push(K_CPU, 9'd0, {tag, "_cpu"});
    push(K_INSTR, 9'd0, {tag, "_instr"});
    push(K_CARR, {8'h00, model_loaded}, {tag, "_carregado"});
    push(K_TAM, model_len[8:0], {tag, "_tamanho"});
  endtask

  task automatic reset_dut();
    Reset         = 1'b1;
    ValidoEntrada = 1'($urandom);
    DadoEntrada   = 8'($urandom);
    Recarregar    = 1'($urandom);
    SaidaPC       = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    model_loaded = 1'b0;
    model_len    = 0;
    push_idle("reset", 1'b0);
    sync();
    Reset = 1'b0;
  endtask

  // Clear sweep: ProntoEntrada must rise exactly after the 256th edge.
  task automatic limpa_check(input int ncyc, input bit offer);
    for (int c = 1; c <= ncyc; c++) begin
      Recarregar    = (c < 256) ? 1'($urandom) : 1'b0;
      ValidoEntrada = (offer && c < 256) ? 1'b1 : 1'b0;
      DadoEntrada   = 8'($urandom);
      SaidaPC       = 8'($urandom);
      @(posedge clk);
      #1;
      push_idle("limpa", c >= 256);
      sync();
    end
    ValidoEntrada = 1'b0;
    Recarregar    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    if (force_gap || $urandom_range(0, 2) == 0) begin
      repeat (force_gap ? 1 : $urandom_range(1, 3)) begin
        ValidoEntrada = 1'b0;
        DadoEntrada   = 8'($urandom);
        Recarregar    = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end
    ValidoEntrada = 1'b1;
    DadoEntrada   = b;
    Recarregar    = 1'($urandom);
    for (int k = 0; k < 20; k++) begin
      if (ProntoEntrada) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    ValidoEntrada = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: byte %02h not accepted, actual pronto %0b required 1",
               b, ProntoEntrada);
    end
  endtask

  task automatic load(input logic [7:0] bs[$]);
    int n = int'(bs[0]);
    send_byte(bs[0]);
    for (int i = 1; i <= n; i++) begin
      push(K_PRONTO, 9'd1, "carrega_pronto");
      push(K_CPU, 9'd0, "carrega_cpu");
      push(K_CARR, 9'd0, "carrega_carregado");
      sync();
      send_byte(bs[i]);
    end
    Recarregar = 1'b0;
    for (int a = 0; a < 256; a++) model_mem[a] = 8'h00;
    for (int i = 1; i <= n; i++) model_mem[i-1] = bs[i];
    model_len    = n;
    model_loaded = 1'b1;
    push(K_CPU, 9'd1, "exec_cpu");
    push(K_PRONTO, 9'd0, "exec_pronto");
    push(K_CARR, 9'd1, "exec_carregado");
    push(K_TAM, model_len[8:0], "exec_tamanho");
    sync();
  endtask

  task automatic read_one(input logic [7:0] a);
    SaidaPC = a;
    push(K_INSTR, {1'b0, model_mem[a]}, "fetch");
    push(K_CPU, 9'd1, "fetch_cpu");
    sync();
  endtask

  task automatic check_reads(input int nrand, input bit all);
    logic [7:0] fixed [5];
    fixed = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd255};
    if (all) begin
      for (int a = 0; a < 256; a++) read_one(8'(a));
    end else begin
      for (int i = 0; i < 5; i++) read_one(fixed[i]);
      for (int i = 0; i < nrand; i++) read_one(8'($urandom));
      if (model_len > 0) read_one(8'(model_len - 1));
      read_one(8'(model_len));
    end
  endtask

  task automatic reload();
    Recarregar    = 1'b1;
    ValidoEntrada = 1'b1;
    DadoEntrada   = 8'($urandom);
    @(posedge clk);
    #1;
    model_loaded = 1'b0;
    push_idle("reload", 1'b0);
    sync();
    limpa_check(256, 1'b1);
  endtask

  initial begin
    logic [7:0] q[$];
    int         n;

    reset_dut();
    limpa_check(300, 1'b0);

    q = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
    load(q);
    check_reads(6, 1'b0);

    reload();
    q = '{8'h00};
    load(q);
    check_reads(0, 1'b1);

    reload();
    force_gap = 1'b1;
    q = '{8'h02, 8'h11, 8'h22};
    load(q);
    force_gap = 1'b0;
    check_reads(4, 1'b0);

    reload();
    send_byte(8'h05);
    send_byte(8'h55);
    send_byte(8'h66);
    reset_dut();
    limpa_check(256, 1'b1);
    q = '{8'h01, 8'h7E};
    load(q);
    check_reads(4, 1'b0);

    reset_dut();
    limpa_check(100, 1'b1);
    reset_dut();
    limpa_check(256, 1'b0);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 60);
      q = {};
      q.push_back(8'(n));
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      load(q);
      check_reads(8, 1'b0);
      reload();
    end

    q = {};
    q.push_back(8'hFF);
    for (int i = 0; i < 255; i++) q.push_back(8'($urandom_range(1, 255)));
    load(q);
    check_reads(8, 1'b0);

    sync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
